ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide engine in the EX stage, fed by the ID/EX register
//  outputs (rs1/rs2 data). Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
//  Raises a stall request that freezes the upstream pipeline until the result is ready.
//  Hands the result to the EX result mux on a one-cycle done pulse.
// PARAMETERS
//  XLEN   32   operand/result width; iteration count = XLEN
// PORTS
//  clk        in   1     pipeline clock
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     M-ext op valid in EX this cycle (level, held while stalled)
//  flush      in   1     jump/branch kill; aborts any operation in progress
//  funct3     in   3     RV32M op select (000 MUL .. 111 REMU)
//  rs1_data   in   XLEN  operand A (dividend / multiplicand)
//  rs2_data   in   XLEN  operand B (divisor / multiplier)
//  stall_req  out  1     freeze PC, IF/ID and ID/EX while operation outstanding
//  done       out  1     one-cycle pulse, result valid
//  result     out  XLEN  selected product half / quotient / remainder
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, count=0, done=0, result=0, all datapath regs 0.
//  FSM states: IDLE, RUN, FIX, DONE.
//  - IDLE: start=1 & flush=0 -> capture |A|,|B| (signedness per funct3), record result
//    sign(s), op class; count=XLEN-1 -> RUN. Special divide cases skip RUN -> DONE.
//  - RUN: one radix-2 step per cycle. MUL*: shift-add into 2*XLEN product.
//    DIV*/REM*: restoring shift-subtract, 1 quotient bit per cycle. count==0 -> FIX.
//  - FIX: apply two's-complement negation to signed results, select high/low half
//    or quotient/remainder into result -> DONE.
//  - DONE: done=1 for exactly this cycle; -> IDLE. A start seen in IDLE the next
//    cycle is a new operation (the EX instruction has advanced).
//  Latency: start-accept cycle to done cycle = XLEN+2 (34); special cases = 1.
//  stall_req = start & ~flush & (state != DONE); combinational, so the issuing
//    instruction holds in EX from its first cycle until done.
//  result holds its value after done until the next FIX/special-case load.
//  Sign rules: MULH signed x signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU
//    unsigned. Remainder takes dividend's sign; quotient sign = signA ^ signB.
//  Special cases (decided in IDLE, no RUN):
//    divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1_data.
//    DIV signed overflow (A=0x80000000, B=-1): quotient 0x80000000, REM -> 0.
//  flush=1 in any state: -> IDLE next edge, no done, result unchanged; flush has
//    priority over a simultaneous start.
//  start dropping mid-RUN without flush: operation completes, done still pulses.
//  Reset mid-operation: immediate return to reset values; no done.
// STRUCTURE
//  Shared package (rv32m_pkg): funct3 encodings for the 8 M ops, FSM state encoding
//    (2-bit), XLEN default.
//  Single module; the FIX-stage negate/select is small enough to stay inline.
//  No sub-module required.
// TESTING
//  1 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done at cycle 34 after start, stall_req
//    high cycles 0..33.
//  2 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000;
//    MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  3 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14,
//    REMU -> 2.
//  4 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
//    each with done one cycle after start.
//  5 Start MUL, assert flush at RUN cycle 10 -> IDLE next edge, no done, stall_req low,
//    result keeps old value; back-to-back start next cycle completes normally.
//  6 Drive rst_n low mid-RUN -> done=0, result=0, stall_req=0 asynchronously; after
//    release a fresh DIV returns the correct quotient.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, funct3 op encodings and the
// muldiv engine state encoding.
package rv32m_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine: radix-2 shift-add multiply and
// restoring divide on magnitudes, with sign fix-up applied once at the end.
module ex_muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    md_state_e       state;
    logic [CW-1:0]   count;
    // hi/lo hold product high/low (multiply) or remainder/quotient (divide);
    // opb holds the multiplicand or divisor magnitude.
    logic [XLEN-1:0] hi, lo, opb;
    logic            neg, is_div, sel_alt;

    logic            a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa       = a_signed & rs1_data[XLEN-1];
        sb       = b_signed & rs2_data[XLEN-1];
        abs_a    = sa ? -rs1_data : rs1_data;
        abs_b    = sb ? -rs2_data : rs2_data;
        div_zero = funct3[2] && (rs2_data == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        if (div_zero) special_res = funct3[1] ? rs1_data : '1;
        else          special_res = funct3[1] ? '0 : rs1_data;
    end

    logic [XLEN:0]   madd, shifted;
    logic [XLEN-1:0] hi_nxt, lo_nxt, sub;
    logic            ge;

    always_comb begin
        madd    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi, lo[XLEN-1]};
        ge      = shifted >= {1'b0, opb};
        sub     = shifted[XLEN-1:0] - opb;
        if (is_div) begin
            hi_nxt = ge ? sub : shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else begin
            hi_nxt = madd[XLEN:1];
            lo_nxt = {madd[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] full_s;
    logic [XLEN-1:0]   q_s, r_s, fix_res;

    always_comb begin
        full_s = neg ? -{hi, lo} : {hi, lo};
        q_s    = neg ? -lo : lo;
        r_s    = neg ? -hi : hi;
        if (is_div) fix_res = sel_alt ? r_s : q_s;
        else        fix_res = sel_alt ? full_s[2*XLEN-1:XLEN] : full_s[XLEN-1:0];
    end

    // Held low during reset so a frozen pipeline is released immediately.
    assign stall_req = rst_n & start & ~flush & (state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            neg     <= 1'b0;
            is_div  <= 1'b0;
            sel_alt <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            is_div  <= funct3[2];
                            sel_alt <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
                            neg     <= (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
                            hi      <= '0;
                            lo      <= funct3[2] ? abs_a : abs_b;
                            opb     <= funct3[2] ? abs_b : abs_a;
                            count   <= CW'(XLEN-1);
                            state   <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        hi    <= hi_nxt;
                        lo    <= lo_nxt;
                        count <= count - 1'b1;
                        if (count == '0) state <= S_FIX;
                    end
                    S_FIX: begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
